register_bank: RTL and testbench

Parametrised multi-register storage block for the SRP16 datapath, replacing single 16-bit registers with a bank of NREGS words of WIDTH bits. Provides per-byte write enables and an upper-byte load (low byte of din into the top byte). It adds in-place increment/decrement/clear operations with registered zero/carry flags, for use as program counter and stack pointer. Two read ports: A drives the shared internal bus (tri-stated when not reading), B is always driven for the ALU.

---
 rtl/register_bank_pkg.sv | 21 ++
 rtl/register_bank_entry.sv | 59 +++++
 rtl/register_bank.sv | 106 ++++++++++
 tb/tb_register_bank.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// Shared definitions for the SRP16 register bank: operation codes and lane geometry.
package register_bank_pkg;

  localparam int unsigned LANE_W = 8;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_WRITE  = 3'd1,
    OP_WRITEU = 3'd2,
    OP_INC    = 3'd3,
    OP_DEC    = 3'd4,
    OP_CLR    = 3'd5,
    OP_RSV6   = 3'd6,
    OP_RSV7   = 3'd7
  } op_t;

  function automatic logic is_reserved(input op_t op);
    return (op == OP_RSV6) || (op == OP_RSV7);
  endfunction

endpackage

// File: rtl/register_bank_entry.sv
// One storage word: byte-lane write, upper-byte load, inc/dec/clear, plus flag candidates.
module register_bank_entry
  import register_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sel,
  input  op_t                      op,
  input  logic [WIDTH-1:0]         din,
  input  logic [WIDTH/LANE_W-1:0]  be,
  output logic [WIDTH-1:0]         q,
  output logic                     carry_nxt,
  output logic                     zero_nxt
);

  localparam int unsigned BYTES = WIDTH / LANE_W;

  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = q;
    case (op)
      OP_WRITE: begin
        for (int unsigned i = 0; i < BYTES; i++) begin
          if (be[i]) nxt[LANE_W*i +: LANE_W] = din[LANE_W*i +: LANE_W];
        end
      end
      OP_WRITEU: nxt[WIDTH-1 -: LANE_W] = din[LANE_W-1:0];
      OP_INC:    nxt = q + 1'b1;
      OP_DEC:    nxt = q - 1'b1;
      OP_CLR:    nxt = '0;
      default:   nxt = q;
    endcase
  end

  // Flags derive from the pre-op value, so both are decided without the adder result.
  always_comb begin
    carry_nxt = 1'b0;
    zero_nxt  = 1'b0;
    if (op == OP_INC) begin
      carry_nxt = (q == '1);
      zero_nxt  = (q == '1);
    end else if (op == OP_DEC) begin
      carry_nxt = (q == '0);
      zero_nxt  = (q == WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (sel) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/register_bank.sv
// Register bank top: address decode, error detection, flag registers and two read ports.
module register_bank
  import register_bank_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned NREGS = 8,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           op,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     din,
  input  logic [WIDTH/8-1:0]   be,
  input  logic [AW-1:0]        raddr_a,
  input  logic                 read_a,
  output logic [WIDTH-1:0]     dout_a,
  input  logic [AW-1:0]        raddr_b,
  output logic [WIDTH-1:0]     dout_b,
  output logic                 zero,
  output logic                 carry,
  output logic                 op_err
);

  op_t              op_e;
  logic             addr_ok;
  logic             bad_op;
  logic             do_op;
  logic             flag_upd;
  logic [NREGS-1:0] sel_vec;
  logic [NREGS-1:0] cand_carry;
  logic [NREGS-1:0] cand_zero;
  logic             sel_carry;
  logic             sel_zero;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  assign op_e     = op_t'(op);
  assign addr_ok  = 32'(waddr) < NREGS;
  assign bad_op   = is_reserved(op_e) || ((op_e != OP_NOP) && !addr_ok);
  assign do_op    = !bad_op && (op_e != OP_NOP);
  assign flag_upd = do_op && ((op_e == OP_INC) || (op_e == OP_DEC));

  always_comb begin
    sel_vec = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      sel_vec[i] = do_op && (32'(waddr) == i);
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_entry
    register_bank_entry #(
      .WIDTH(WIDTH)
    ) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .sel       (sel_vec[g]),
      .op        (op_e),
      .din       (din),
      .be        (be),
      .q         (regs[g]),
      .carry_nxt (cand_carry[g]),
      .zero_nxt  (cand_zero[g])
    );
  end

  // Only the addressed entry's candidates matter; sel_vec is one-hot or empty.
  always_comb begin
    sel_carry = 1'b0;
    sel_zero  = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (sel_vec[i]) begin
        sel_carry = cand_carry[i];
        sel_zero  = cand_zero[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero   <= 1'b0;
      carry  <= 1'b0;
      op_err <= 1'b0;
    end else begin
      op_err <= bad_op;
      if (flag_upd) begin
        carry <= sel_carry;
        zero  <= sel_zero;
      end
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (32'(raddr_a) == i) rd_a = regs[i];
      if (32'(raddr_b) == i) rd_b = regs[i];
    end
  end

  assign dout_b = rd_b;
  assign dout_a = read_a ? rd_a : 'z;

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: directed scenarios plus random ops against an array model.
module tb_register_bank;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 6;
  localparam int unsigned AW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [2:0]     op = '0;
  logic [AW-1:0]  waddr = '0;
  logic [W-1:0]   din = '0;
  logic [W/8-1:0] be = '0;
  logic [AW-1:0]  raddr_a = '0;
  logic           read_a = 1'b0;
  wire  [W-1:0]   dout_a;
  logic [AW-1:0]  raddr_b = '0;
  logic [W-1:0]   dout_b;
  logic           zero, carry, op_err;

  always #5 clk = ~clk;

  register_bank #(
    .WIDTH(W),
    .NREGS(N)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .op      (op),
    .waddr   (waddr),
    .din     (din),
    .be      (be),
    .raddr_a (raddr_a),
    .read_a  (read_a),
    .dout_a  (dout_a),
    .raddr_b (raddr_b),
    .dout_b  (dout_b),
    .zero    (zero),
    .carry   (carry),
    .op_err  (op_err)
  );

  typedef struct {
    bit          post;
    bit          rda;
    int unsigned a;
    int unsigned b;
    bit          z;
    bit          c;
    bit          e;
  } exp_t;

  exp_t        sb[$];
  int unsigned mem[N];
  bit          mz, mc, me;
  int          total = 0;
  int          bad = 0;

  function automatic int unsigned model_rd(input int unsigned a);
    return (a < N) ? mem[a] : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // A disabled port A must not drive stored data; Z or a 2-state 0 are both acceptable.
  task automatic chk_hiz(input string nm);
    total++;
    if (!((dout_a === {W{1'bz}}) || (dout_a === '0))) begin
      bad++;
      $display("FAIL %s: got %h expected high-Z at %0t", nm, dout_a, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mem[i] = 0;
    mz = 1'b0;
    mc = 1'b0;
    me = 1'b0;
  endtask

  task automatic model_step(input int unsigned o, input int unsigned wa,
                            input int unsigned d, input int unsigned bv);
    bit          err;
    int unsigned old;
    err = (o >= 6) || ((o != 0) && (wa >= N));
    if (!err && o != 0) begin
      old = mem[wa];
      case (o)
        1: for (int k = 0; k < 2; k++)
             if (bv[k]) mem[wa] = (mem[wa] & ~(32'hFF << (8*k))) | (d & (32'hFF << (8*k)));
        2: mem[wa] = (old & 32'h00FF) | ((d & 32'hFF) << 8);
        3: begin
             mem[wa] = (old + 1) % 65536;
             mc = (old == 65535);
             mz = (mem[wa] == 0);
           end
        4: begin
             mem[wa] = (old + 65535) % 65536;
             mc = (old == 0);
             mz = (old == 1);
           end
        default: mem[wa] = 0;
      endcase
    end
    me = err;
  endtask

  task automatic cycle(input int unsigned o, input int unsigned wa, input int unsigned d,
                       input int unsigned bv, input int unsigned ra, input int unsigned rb,
                       input bit rda);
    exp_t x;
    @(negedge clk);
    #1;
    op      = o[2:0];
    waddr   = wa[AW-1:0];
    din     = d[W-1:0];
    be      = bv[1:0];
    raddr_a = ra[AW-1:0];
    raddr_b = rb[AW-1:0];
    read_a  = rda;
    x.post = 1'b0; x.rda = rda; x.a = model_rd(ra); x.b = model_rd(rb);
    x.z = mz; x.c = mc; x.e = me;
    sb.push_back(x);
    model_step(o, wa, d, bv);
    x.post = 1'b1; x.a = model_rd(ra); x.b = model_rd(rb);
    x.z = mz; x.c = mc; x.e = me;
    sb.push_back(x);
  endtask

  // Assert reset a few ns after a rising edge, i.e. mid-cycle.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    op      = '0;
    read_a  = 1'b1;
    raddr_a = 3'd2;
    raddr_b = 3'd1;
    rst_n   = 1'b0;
    #1;
    chk("rst_dout_b", dout_b, 0);
    chk("rst_dout_a", dout_a, 0);
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
    chk("rst_op_err", op_err, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0 && !sb[0].post) begin
        x = sb.pop_front();
        if (x.rda) chk("pre_dout_a", dout_a, x.a);
        else       chk_hiz("pre_dout_a_z");
        chk("pre_dout_b", dout_b, x.b);
      end
      @(posedge clk);
      #1;
      if (sb.size() > 0 && sb[0].post) begin
        x = sb.pop_front();
        if (x.rda) chk("dout_a", dout_a, x.a);
        else       chk_hiz("dout_a_z");
        chk("dout_b", dout_b, x.b);
        chk("zero", zero, x.z);
        chk("carry", carry, x.c);
        chk("op_err", op_err, x.e);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) cycle(1, i, 16'hFFFF, 3, i, i, 1);
    cycle(3, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 16'hFFFF, 3, 0, 0, 1);
    cycle(6, 0, 0, 0, 1, 1, 1);
    mid_reset();

    cycle(1, 3, 16'hABCD, 1, 3, 3, 1);
    cycle(1, 3, 16'h1200, 2, 3, 3, 1);
    cycle(1, 1, 16'h1234, 3, 1, 1, 1);
    cycle(2, 1, 16'h0077, 3, 1, 1, 1);
    cycle(1, 2, 16'hFFFF, 3, 2, 2, 1);
    cycle(3, 2, 0, 0, 2, 2, 1);
    cycle(4, 2, 0, 0, 2, 2, 1);
    cycle(1, 2, 16'h0001, 3, 2, 2, 1);
    cycle(4, 2, 0, 0, 2, 2, 1);
    cycle(1, 4, 16'h5555, 3, 4, 4, 1);
    cycle(0, 0, 0, 0, 4, 4, 1);
    cycle(0, 0, 0, 0, 4, 4, 0);
    cycle(6, 2, 16'hBEEF, 3, 2, 2, 1);
    cycle(3, 7, 0, 0, 7, 2, 1);
    cycle(1, 6, 16'h9999, 3, 6, 3, 1);
    cycle(7, 1, 0, 0, 1, 1, 1);
    cycle(0, 7, 0, 0, 1, 1, 1);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      cycle($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 16'hFFFF),
            $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 1)));
    end
    cycle(0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
